// File: rtl/axi_r_channel_slave.sv
// AXI read-channel slave: turns AR bursts into single-word SRAM reads and returns R beats via a 2-entry FIFO.
// Optional feature: define AXI_RSLV_RANGE_CHK_EN to flag beats addressing beyond the SRAM as SLVERR.
module axi_r_channel_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int SRAM_AW    = 12
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic [3:0]            ARLEN,
    input  logic [2:0]            ARSIZE,
    input  logic [1:0]            ARBURST,
    input  logic [ID_WIDTH-1:0]   ARID,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST,
    output logic [ID_WIDTH-1:0]   RID,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic                  sram_ren,
    output logic [SRAM_AW-1:0]    sram_raddr,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);
    localparam int STRB = DATA_WIDTH / 8;
    localparam int BSH  = $clog2(STRB);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                state_reg;
    logic                  arready_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [3:0]            len_reg;
    logic [3:0]            cnt_reg;
    logic [2:0]            size_reg;
    logic [1:0]            burst_reg;
    logic [ID_WIDTH-1:0]   id_reg;

    logic                  infl_reg;
    logic                  infl_err_reg;
    logic                  infl_last_reg;
    logic [ID_WIDTH-1:0]   infl_id_reg;

    logic [1:0]            count_reg;
    logic                  wr_ptr_reg;
    logic                  rd_ptr_reg;
    logic [DATA_WIDTH-1:0] fifo_data_reg [2];
    logic                  fifo_err_reg  [2];
    logic                  fifo_last_reg [2];
    logic [ID_WIDTH-1:0]   fifo_id_reg   [2];

    logic                  size_err;
    logic                  range_err;
    logic                  beat_err;
    logic                  pop;
    logic                  push;
    logic                  issue;
    logic [ADDR_WIDTH-1:0] addr_step;

    assign size_err = (int'(size_reg) > BSH);
`ifdef AXI_RSLV_RANGE_CHK_EN
    assign range_err = ((addr_reg >> (SRAM_AW + BSH)) != '0);
`else
    assign range_err = 1'b0;
`endif
    assign beat_err  = (burst_reg == 2'b11) || size_err || range_err;
    assign addr_step = ADDR_WIDTH'(1) << size_reg;

    assign pop  = (count_reg != 2'd0) && RREADY;
    assign push = infl_reg;
    // Credit counts the slot freed by a same-cycle pop so streaming has no bubbles.
    assign issue = (state_reg == ISSUE) &&
                   (({1'b0, count_reg} + {2'b00, infl_reg}) < (3'd2 + {2'b00, pop}));

    assign sram_ren   = issue && !beat_err;
    assign sram_raddr = addr_reg[SRAM_AW+BSH-1:BSH];
    assign ARREADY    = arready_reg;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_reg   <= IDLE;
            arready_reg <= 1'b0;
            addr_reg    <= '0;
            len_reg     <= '0;
            cnt_reg     <= '0;
            size_reg    <= '0;
            burst_reg   <= '0;
            id_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    arready_reg <= 1'b1;
                    if (ARVALID && arready_reg) begin
                        addr_reg    <= ARADDR;
                        len_reg     <= ARLEN;
                        size_reg    <= ARSIZE;
                        burst_reg   <= ARBURST;
                        id_reg      <= ARID;
                        cnt_reg     <= '0;
                        arready_reg <= 1'b0;
                        state_reg   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        // WRAP deliberately walks like INCR; FIXED re-reads one address.
                        if (burst_reg != 2'b00)
                            addr_reg <= addr_reg + addr_step;
                        cnt_reg <= cnt_reg + 4'd1;
                        if (cnt_reg == len_reg) begin
                            state_reg   <= IDLE;
                            arready_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            infl_reg      <= 1'b0;
            infl_err_reg  <= 1'b0;
            infl_last_reg <= 1'b0;
            infl_id_reg   <= '0;
        end else begin
            infl_reg      <= issue;
            infl_err_reg  <= beat_err;
            infl_last_reg <= (cnt_reg == len_reg);
            infl_id_reg   <= id_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge ACLK) begin
                if (ARESET) begin
                    fifo_data_reg[gi] <= '0;
                    fifo_err_reg[gi]  <= 1'b0;
                    fifo_last_reg[gi] <= 1'b0;
                    fifo_id_reg[gi]   <= '0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    fifo_data_reg[gi] <= infl_err_reg ? '0 : sram_rdata;
                    fifo_err_reg[gi]  <= infl_err_reg;
                    fifo_last_reg[gi] <= infl_last_reg;
                    fifo_id_reg[gi]   <= infl_id_reg;
                end
            end
        end
    endgenerate

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            count_reg  <= '0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else begin
            if (push)
                wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)
                rd_ptr_reg <= ~rd_ptr_reg;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Outputs read the FIFO head; they hold while RVALID && !RREADY because the head only moves on pop.
    assign RVALID = (count_reg != 2'd0);
    assign RDATA  = RVALID ? fifo_data_reg[rd_ptr_reg] : '0;
    assign RRESP  = (RVALID && fifo_err_reg[rd_ptr_reg]) ? 2'b10 : 2'b00;
    assign RLAST  = RVALID && fifo_last_reg[rd_ptr_reg];
    assign RID    = RVALID ? fifo_id_reg[rd_ptr_reg] : '0;

endmodule
